// File: rtl/yuv422_fb_pkg.sv
// Shared types for the YUV422 framebuffer: pixel/word types, writer FSM states, pixel-pair packing.
package yuv422_fb_pkg;

  localparam int unsigned PIXEL_W = 16;
  localparam int unsigned WORD_W  = 32;

  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef logic [WORD_W-1:0]  word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    FULL = 2'd3
  } wr_state_e;

  // First pixel lands in the low half so 16-bit reads at 2n / 2n+1 see pixel order.
  function automatic word_t pack_word(input pixel_t hi, input pixel_t lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/yuv422_fb_writer_if.sv
// Pixel stream in / RAM write port out of the framebuffer writer; master = source side, slave = writer.
interface yuv422_fb_writer_if
  import yuv422_fb_pkg::*;
#(
  parameter int unsigned LINES = 16
);

  localparam int unsigned AW = $clog2(LINES);

  logic          sof_i;
  pixel_t        px_d_i;
  logic          px_valid_i;
  logic          px_ready_o;
  logic          eof_i;
  logic [AW-1:0] wr_addr_o;
  word_t         wr_d_o;
  logic          wr_en_o;
  logic          busy_o;
  logic          frame_done_o;

  modport master (
    output sof_i, px_d_i, px_valid_i, eof_i,
    input  px_ready_o, wr_addr_o, wr_d_o, wr_en_o, busy_o, frame_done_o
  );

  modport slave (
    input  sof_i, px_d_i, px_valid_i, eof_i,
    output px_ready_o, wr_addr_o, wr_d_o, wr_en_o, busy_o, frame_done_o
  );

endinterface

// File: rtl/yuv422_fb_writer.sv
// Packs a 16-bit YUV422 pixel stream into 32-bit framebuffer words with a registered RAM write port.
// Build option YUV_FB_WR_ODD_FLUSH_EN: flush a trailing odd pixel as {16'h0000, pixel} instead of dropping it.
module yuv422_fb_writer
  import yuv422_fb_pkg::*;
#(
  parameter int unsigned LINES = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  yuv422_fb_writer_if.slave bus
);

  localparam int unsigned AW   = $clog2(LINES);
  localparam logic [AW-1:0] LAST = AW'(LINES - 1);

  wr_state_e     state, state_nxt;
  logic [AW-1:0] word_cnt, word_cnt_nxt;
  pixel_t        hold, hold_nxt;
  logic [AW-1:0] wr_addr_nxt;
  word_t         wr_d_nxt;
  logic          wr_en_nxt;
  logic          done_nxt;
  logic          accept;

  assign accept = bus.px_valid_i && bus.px_ready_o;

  // Next-state and next-output decode; sof overrides everything, including eof.
  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    hold_nxt     = hold;
    wr_addr_nxt  = bus.wr_addr_o;
    wr_d_nxt     = bus.wr_d_o;
    wr_en_nxt    = 1'b0;
    done_nxt     = 1'b0;

    if (bus.sof_i) begin
      word_cnt_nxt = '0;
      if (accept) begin
        hold_nxt  = bus.px_d_i;
        state_nxt = HI;
      end else begin
        hold_nxt  = '0;
        state_nxt = LO;
      end
    end else begin
      case (state)
        LO: begin
          if (accept) begin
            if (bus.eof_i) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
`ifdef YUV_FB_WR_ODD_FLUSH_EN
              wr_en_nxt   = 1'b1;
              wr_addr_nxt = word_cnt;
              wr_d_nxt    = pack_word(pixel_t'(0), bus.px_d_i);
              if (word_cnt == LAST) state_nxt = FULL;
`endif
            end else begin
              hold_nxt  = bus.px_d_i;
              state_nxt = HI;
            end
          end
        end
        HI: begin
          if (accept) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = word_cnt;
            wr_d_nxt    = pack_word(bus.px_d_i, hold);
            hold_nxt    = '0;
            if (bus.eof_i) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end else if (word_cnt == LAST) begin
              done_nxt  = 1'b1;
              state_nxt = FULL;
            end else begin
              word_cnt_nxt = word_cnt + AW'(1);
              state_nxt    = LO;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers; ready/busy follow the next state so they stay purely registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      word_cnt         <= '0;
      hold             <= '0;
      bus.wr_addr_o    <= '0;
      bus.wr_d_o       <= '0;
      bus.wr_en_o      <= 1'b0;
      bus.frame_done_o <= 1'b0;
      bus.px_ready_o   <= 1'b0;
      bus.busy_o       <= 1'b0;
    end else begin
      state            <= state_nxt;
      word_cnt         <= word_cnt_nxt;
      hold             <= hold_nxt;
      bus.wr_addr_o    <= wr_addr_nxt;
      bus.wr_d_o       <= wr_d_nxt;
      bus.wr_en_o      <= wr_en_nxt;
      bus.frame_done_o <= done_nxt;
      bus.px_ready_o   <= (state_nxt == LO) || (state_nxt == HI);
      bus.busy_o       <= (state_nxt == LO) || (state_nxt == HI);
    end
  end

endmodule
